// File: rtl/ascii_coef_loader_pkg.sv
// Shared constants, state and error encodings for the ASCII coefficient loader.
package ascii_coef_pkg;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DROP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_CHAR  = 2'd1,
    ERR_OVF   = 2'd2,
    ERR_EMPTY = 2'd3
  } err_t;

  function automatic logic is_space(input logic [7:0] c);
    return (c == CH_SPACE) || (c == CH_CR) || (c == CH_LF);
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

endpackage

// File: rtl/ascii_coef_loader_if.sv
// Byte-stream handshake from the UART receiver into the coefficient loader.
interface ascii_coef_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ascii_coef_loader_mac.sv
// Decimal shift-in: mag*10 + digit, flagged when the result exceeds 2^(COEF_W-1).
// The product is formed wide enough that it can never wrap before the compare.
module dec_digit_mac #(
  parameter int COEF_W = 12
) (
  input  logic [COEF_W:0] mag,
  input  logic [3:0]      digit,
  output logic [COEF_W:0] mag_nxt,
  output logic            ovf
);
  localparam int MW = COEF_W + 5;
  localparam logic [MW-1:0] LIMIT = MW'(1) << (COEF_W - 1);

  logic [MW-1:0] acc;

  // Multiply-accumulate and limit compare
  always_comb begin
    acc     = MW'(mag) * MW'(10) + MW'(digit);
    mag_nxt = acc[COEF_W:0];
    ovf     = acc > LIMIT;
  end
endmodule

// File: rtl/ascii_coef_loader.sv
// ASCII signed-decimal parser feeding an N-entry coefficient bank.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no number in progress
// ST_ACCUM  | sign and/or digits collected, waiting for more or commit
// ST_COMMIT | single cycle: write the number into bank[wp], in_ready low
// ST_DROP   | bad number, discard bytes until the commit character
module ascii_coef_loader
  import ascii_coef_pkg::*;
#(
  parameter int         COEF_W      = 12,
  parameter int         N_COEF      = 4,
  parameter int         MAX_DIGITS  = 4,
  parameter logic [7:0] COMMIT_CHAR = 8'h63,
  parameter int         IDX_W       = $clog2(N_COEF)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  ascii_coef_loader_if.slave         bus,
  output logic                       coef_valid,
  output logic [COEF_W-1:0]          coef_data,
  output logic [IDX_W-1:0]           coef_idx,
  output logic [N_COEF*COEF_W-1:0]   coef_bank,
  output logic                       bank_full,
  output logic                       err,
  output logic [1:0]                 err_code
);
  localparam int NDW = $clog2(MAX_DIGITS + 2);
  localparam logic [COEF_W:0] MAG_LIM = {2'b01, {(COEF_W-1){1'b0}}};

  state_t             state, state_nxt;
  logic [COEF_W:0]    mag, mag_nxt, mac_mag;
  logic               neg, neg_nxt, mac_ovf;
  logic [NDW-1:0]     ndig, ndig_nxt;
  logic [IDX_W-1:0]   wp;
  logic [COEF_W-1:0]  bank [N_COEF];
  logic [COEF_W-1:0]  commit_val;
  logic               accept, err_hit;
  err_t               err_hit_code;
  logic [7:0]         ch;

  assign ch           = bus.in_data;
  assign bus.in_ready = enable && (state != ST_COMMIT);
  assign accept       = bus.in_valid && bus.in_ready;
  assign commit_val   = COEF_W'(neg ? -mag : mag);

  dec_digit_mac #(.COEF_W(COEF_W)) u_mac (
    .mag     (mag),
    .digit   (ch[3:0]),
    .mag_nxt (mac_mag),
    .ovf     (mac_ovf)
  );

  for (genvar k = 0; k < N_COEF; k++) begin : g_flat
    assign coef_bank[k*COEF_W +: COEF_W] = bank[k];
  end

  // Next-state and number-assembly decode
  always_comb begin
    state_nxt    = state;
    mag_nxt      = mag;
    neg_nxt      = neg;
    ndig_nxt     = ndig;
    err_hit      = 1'b0;
    err_hit_code = ERR_NONE;
    case (state)
      ST_IDLE, ST_ACCUM: begin
        if (accept && !is_space(ch)) begin
          if (is_digit(ch)) begin
            if ((ndig == NDW'(MAX_DIGITS)) || mac_ovf) begin
              state_nxt    = ST_DROP;
              err_hit      = 1'b1;
              err_hit_code = ERR_OVF;
            end else begin
              state_nxt = ST_ACCUM;
              mag_nxt   = mac_mag;
              ndig_nxt  = ndig + NDW'(1);
            end
          end else if (ch == CH_MINUS) begin
            if (state == ST_IDLE) begin
              state_nxt = ST_ACCUM;
              neg_nxt   = 1'b1;
            end else begin
              state_nxt    = ST_DROP;
              err_hit      = 1'b1;
              err_hit_code = ERR_CHAR;
            end
          end else if (ch == COMMIT_CHAR) begin
            if (ndig == '0) begin
              state_nxt    = ST_IDLE;
              err_hit      = 1'b1;
              err_hit_code = ERR_EMPTY;
              mag_nxt      = '0;
              neg_nxt      = 1'b0;
              ndig_nxt     = '0;
            end else if (!neg && (mag == MAG_LIM)) begin
              // +2^(W-1) passes the digit check but has no positive encoding
              state_nxt    = ST_IDLE;
              err_hit      = 1'b1;
              err_hit_code = ERR_OVF;
              mag_nxt      = '0;
              neg_nxt      = 1'b0;
              ndig_nxt     = '0;
            end else begin
              state_nxt = ST_COMMIT;
            end
          end else begin
            state_nxt    = ST_DROP;
            err_hit      = 1'b1;
            err_hit_code = ERR_CHAR;
          end
        end
      end
      ST_COMMIT: begin
        state_nxt = ST_IDLE;
        mag_nxt   = '0;
        neg_nxt   = 1'b0;
        ndig_nxt  = '0;
      end
      ST_DROP: begin
        if (accept && (ch == COMMIT_CHAR)) begin
          state_nxt = ST_IDLE;
          mag_nxt   = '0;
          neg_nxt   = 1'b0;
          ndig_nxt  = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!enable) begin
      state_nxt = ST_IDLE;
      mag_nxt   = '0;
      neg_nxt   = 1'b0;
      ndig_nxt  = '0;
      err_hit   = 1'b0;
    end
  end

  // State, bank write, write pointer and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mag        <= '0;
      neg        <= 1'b0;
      ndig       <= '0;
      wp         <= '0;
      bank_full  <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      coef_valid <= 1'b0;
      coef_data  <= '0;
      coef_idx   <= '0;
      for (int k = 0; k < N_COEF; k++) bank[k] <= '0;
    end else begin
      state      <= state_nxt;
      mag        <= mag_nxt;
      neg        <= neg_nxt;
      ndig       <= ndig_nxt;
      coef_valid <= 1'b0;
      if (!enable) begin
        wp        <= '0;
        bank_full <= 1'b0;
        err       <= 1'b0;
        err_code  <= ERR_NONE;
      end else begin
        if (err_hit) begin
          err      <= 1'b1;
          err_code <= err_hit_code;
        end
        if (state == ST_COMMIT) begin
          bank[wp]   <= commit_val;
          coef_data  <= commit_val;
          coef_idx   <= wp;
          coef_valid <= 1'b1;
          if (wp == IDX_W'(N_COEF - 1)) begin
            wp        <= '0;
            bank_full <= 1'b1;
          end else begin
            wp <= wp + IDX_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ascii_coef_loader.sv
// Directed bench for ascii_coef_loader (COEF_W=12, N_COEF=4).
module tb_ascii_coef_loader;
  import ascii_coef_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        coef_valid, bank_full, err;
  logic [11:0] coef_data;
  logic [1:0]  coef_idx, err_code;
  logic [47:0] coef_bank;
  int          n_checks = 0;
  int          n_fail = 0;

  ascii_coef_loader_if bus ();

  ascii_coef_loader dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .bus        (bus),
    .coef_valid (coef_valid),
    .coef_data  (coef_data),
    .coef_idx   (coef_idx),
    .coef_bank  (coef_bank),
    .bank_full  (bank_full),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] slot(input int k);
    return coef_bank[k*12 +: 12];
  endfunction

  task automatic send_byte(input logic [7:0] c);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = c;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic expect_write(input string tag, input logic [11:0] data, input logic [1:0] idx);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 64'(coef_valid), 64'd1);
    chk({tag, "_data"}, 64'(coef_data), 64'(data));
    chk({tag, "_idx"}, 64'(coef_idx), 64'(idx));
    chk({tag, "_slot"}, 64'(slot(int'(idx))), 64'(data));
  endtask

  task automatic expect_no_write(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_nowrite"}, 64'(coef_valid), 64'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_valid", 64'(coef_valid), 64'd0);
    chk("rst_data", 64'(coef_data), 64'd0);
    chk("rst_idx", 64'(coef_idx), 64'd0);
    chk("rst_bank", 64'(coef_bank), 64'd0);
    chk("rst_full", 64'(bank_full), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_code", 64'(err_code), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);

    send_str("123c");
    expect_write("t1", 12'd123, 2'd0);
    chk("t1_err", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    chk("t1_pulse_end", 64'(coef_valid), 64'd0);

    send_str("-2048c");
    expect_write("t2_min", 12'h800, 2'd1);
    send_str("2048c");
    chk("t2_err", 64'(err), 64'd1);
    chk("t2_code", 64'(err_code), 64'd2);
    expect_no_write("t2");
    chk("t2_slot2", 64'(slot(2)), 64'd0);

    send_str("12x3c");
    chk("t3_code_char", 64'(err_code), 64'd1);
    expect_no_write("t3");
    send_str("5c");
    expect_write("t3_good", 12'd5, 2'd2);
    chk("t3_err_sticky", 64'(err), 64'd1);
    send_str("c");
    chk("t3_code_empty", 64'(err_code), 64'd3);
    send_str("--5c");
    chk("t3_code_dblminus", 64'(err_code), 64'd1);

    enable = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    chk("clr_err", 64'(err), 64'd0);
    chk("clr_code", 64'(err_code), 64'd0);
    chk("clr_bank_kept", 64'(slot(0)), 64'd123);

    send_str("1c");
    expect_write("t4_1", 12'd1, 2'd0);
    send_str("2c");
    expect_write("t4_2", 12'd2, 2'd1);
    send_str("3c");
    expect_write("t4_3", 12'd3, 2'd2);
    chk("t4_not_full", 64'(bank_full), 64'd0);
    send_str("4c");
    expect_write("t4_4", 12'd4, 2'd3);
    chk("t4_full", 64'(bank_full), 64'd1);
    chk("t4_bank", 64'(coef_bank), 64'h004_003_002_001);
    send_str("9c");
    expect_write("t4_wrap", 12'd9, 2'd0);
    chk("t4_full_stays", 64'(bank_full), 64'd1);

    send_str("-12 34c");
    expect_write("t5_neg", 12'hB2E, 2'd1);
    send_str("12345");
    chk("t5_ovf_code", 64'(err_code), 64'd2);
    send_str("c");
    expect_no_write("t5");

    bus.in_valid = 1'b1;
    bus.in_data  = "7";
    @(posedge clk);
    #1;
    bus.in_data = "c";
    @(posedge clk);
    #1;
    bus.in_data = "8";
    chk("t5_ready_low", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("t5_hold_valid", 64'(coef_valid), 64'd1);
    chk("t5_hold_data", 64'(coef_data), 64'd7);
    chk("t5_ready_back", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_data = "c";
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    expect_write("t5_next", 12'd8, 2'd3);

    send_str("12");
    rst = 1'b1;
    #2;
    chk("t6_rst_bank", 64'(coef_bank), 64'd0);
    chk("t6_rst_full", 64'(bank_full), 64'd0);
    chk("t6_rst_err", 64'(err), 64'd0);
    chk("t6_rst_data", 64'(coef_data), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_str("7c");
    expect_write("t6_after_rst", 12'd7, 2'd0);

    send_str("xc45");
    chk("t6_err_set", 64'(err), 64'd1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    chk("t6_en_err", 64'(err), 64'd0);
    chk("t6_en_kept", 64'(slot(0)), 64'd7);
    send_str("6c");
    expect_write("t6_after_en", 12'd6, 2'd0);

    send_str("3c");
    enable = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    chk("t6_cancel_valid", 64'(coef_valid), 64'd0);
    chk("t6_cancel_slot", 64'(slot(1)), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
